// File: rtl/isp_uart_tx_stream_if.sv
// Write-side and line-status signals of the ISP UART byte transmitter.
// The producer (bench or host state machine) uses master; the transmitter uses slave.
interface isp_uart_tx_stream_if #(
    parameter int FIFO_AW = 3
);
    logic               wr_en;
    logic [7:0]         wr_data;
    logic               full;
    logic               empty;
    logic [FIFO_AW:0]   count;
    logic               busy;
    logic               uart_tx;

    modport master (
        output wr_en, wr_data,
        input  full, empty, count, busy, uart_tx
    );

    modport slave (
        input  wr_en, wr_data,
        output full, empty, count, busy, uart_tx
    );
endinterface

// File: rtl/isp_uart_tx_stream.sv
// 8N1 UART transmitter fed by a small circular FIFO; drives the SoC ISP UART rx pin.
// Line and busy are registered one cycle behind the FSM state, so no input reaches uart_tx combinationally.
module isp_uart_tx_stream #(
    parameter int CLK_DIV = 434,
    parameter int FIFO_AW = 3
) (
    input  logic               clk,
    input  logic               rst,
    isp_uart_tx_stream_if.slave bus
);
    localparam int                 DEPTH     = 2 ** FIFO_AW;
    localparam logic [15:0]        DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [FIFO_AW:0]   DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = 1;
    localparam logic [FIFO_AW:0]   CNT_ONE   = 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_AW:0]   count_reg, count_next;
    logic               full_reg, empty_reg;

    state_t             state_reg, state_next;
    logic [15:0]        div_reg, div_next;
    logic [2:0]         bit_idx_reg, bit_idx_next;
    logic [7:0]         shift_reg, shift_next;
    logic               uart_tx_reg, busy_reg;
    logic               line_bit;
    logic               push, pop;

    // A write against a full FIFO is dropped even when a pop frees a slot this cycle.
    assign push = bus.wr_en & ~full_reg;

    always_comb begin
        state_next   = state_reg;
        div_next     = div_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        pop          = 1'b0;
        line_bit     = 1'b1;
        case (state_reg)
            IDLE: begin
                if (!empty_reg) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr_reg];
                    div_next   = 16'd0;
                    state_next = START;
                end
            end
            START: begin
                line_bit = 1'b0;
                if (div_reg == DIV_LAST) begin
                    div_next     = 16'd0;
                    bit_idx_next = 3'd0;
                    state_next   = DATA;
                end else begin
                    div_next = div_reg + 16'd1;
                end
            end
            DATA: begin
                line_bit = shift_reg[0];
                if (div_reg == DIV_LAST) begin
                    div_next   = 16'd0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    div_next = div_reg + 16'd1;
                end
            end
            STOP: begin
                if (div_reg == DIV_LAST) begin
                    div_next = 16'd0;
                    // Chain straight into the next start bit so back-to-back frames have no gap.
                    if (!empty_reg) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr_reg];
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    div_next = div_reg + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            full_reg    <= 1'b0;
            empty_reg   <= 1'b1;
            state_reg   <= IDLE;
            div_reg     <= 16'd0;
            bit_idx_reg <= 3'd0;
            shift_reg   <= 8'd0;
            uart_tx_reg <= 1'b1;
            busy_reg    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            count_reg   <= count_next;
            full_reg    <= (count_next == DEPTH_CNT);
            empty_reg   <= (count_next == '0);
            state_reg   <= state_next;
            div_reg     <= div_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            uart_tx_reg <= line_bit;
            busy_reg    <= (state_reg != IDLE);
        end
    end

    assign bus.full    = full_reg;
    assign bus.empty   = empty_reg;
    assign bus.count   = count_reg;
    assign bus.busy    = busy_reg;
    assign bus.uart_tx = uart_tx_reg;
endmodule

// File: tb/tb_isp_uart_tx_stream.sv
// Directed bench for isp_uart_tx_stream: cycle-exact line checks plus a UART decoder
// that compares received frames against a queue of bytes expected on the line.
module tb_isp_uart_tx_stream;
    localparam int CLK_DIV = 4;
    localparam int FIFO_AW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    isp_uart_tx_stream_if #(.FIFO_AW(FIFO_AW)) bus ();

    isp_uart_tx_stream #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int frames   = 0;
    logic [7:0] sb [$];
    int starts [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step(1);
    endtask

    task automatic drain(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (sb.size() == 0 && bus.busy === 1'b0 && bus.empty === 1'b1) begin
                done = 1'b1;
                break;
            end
            step(1);
        end
        check(tag, done, 1'b1);
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k < CLK_DIV) return 1'b0;
        if (k < 9 * CLK_DIV) return d[(k - CLK_DIV) / CLK_DIV];
        return 1'b1;
    endfunction

    // Line decoder: samples each bit in its middle; frames overlapped by a reset are discarded.
    initial begin
        forever begin
            logic [7:0] d;
            logic       start_b, stop_b;
            logic [7:0] exp;
            bit         saw;
            int         t;
            @(negedge clk);
            if (rst !== 1'b0 || bus.uart_tx !== 1'b0) continue;
            t   = cyc;
            saw = 1'b0;
            for (int j = 0; j < CLK_DIV / 2; j++) begin @(negedge clk); saw |= rst; end
            start_b = bus.uart_tx;
            for (int b = 0; b < 8; b++) begin
                for (int j = 0; j < CLK_DIV; j++) begin @(negedge clk); saw |= rst; end
                d[b] = bus.uart_tx;
            end
            for (int j = 0; j < CLK_DIV; j++) begin @(negedge clk); saw |= rst; end
            stop_b = bus.uart_tx;
            check("frame_expected", (sb.size() != 0), 1'b1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                if (!saw) begin
                    check("frame_start", start_b, 1'b0);
                    check("frame_data", d, exp);
                    check("frame_stop", stop_b, 1'b1);
                    starts.push_back(t);
                    frames++;
                    $display("frame %0d data=0x%02h expected=0x%02h at cycle %0d", frames, d, exp, t);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, m, bad;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;

        // Reset values
        step(3);
        check("rst_uart_tx", bus.uart_tx, 1'b1);
        check("rst_busy",    bus.busy,    1'b0);
        check("rst_empty",   bus.empty,   1'b1);
        check("rst_full",    bus.full,    1'b0);
        check("rst_count",   bus.count,   3'd0);
        rst = 1'b0;
        step(2);

        // Single byte 0xA5 with cycle-exact line shape
        sb.push_back(8'hA5);
        bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
        step(1);
        n = cyc;
        bus.wr_en = 1'b0;
        check("a5_count_n", bus.count, 3'd1);
        check("a5_empty_n", bus.empty, 1'b0);
        step(1);
        check("a5_idle_n1", bus.uart_tx, 1'b1);
        check("a5_busy_n1", bus.busy, 1'b0);
        step(1);
        check("a5_empty_n2", bus.empty, 1'b1);
        check("a5_busy_n2",  bus.busy,  1'b1);
        bad = 0;
        for (int k = 0; k < 10 * CLK_DIV; k++) begin
            if (bus.uart_tx !== frame_bit(8'hA5, k)) bad++;
            if (k == 10 * CLK_DIV - 1) check("a5_busy_last", bus.busy, 1'b1);
            step(1);
        end
        check("a5_line_shape", bad, 0);
        check("a5_busy_n42", bus.busy, 1'b0);
        check("a5_tx_n42",   bus.uart_tx, 1'b1);
        check("a5_cycle",    cyc - n, 42);
        drain("a5_drain");

        // Back-to-back 0x00, 0xFF
        sb.push_back(8'h00);
        sb.push_back(8'hFF);
        bus.wr_en = 1'b1; bus.wr_data = 8'h00;
        step(1);
        m = cyc;
        bus.wr_data = 8'hFF;
        step(1);
        bus.wr_en = 1'b0;
        wait_until(m + 41);
        check("b2b_first_stop", bus.uart_tx, 1'b1);
        step(1);
        check("b2b_second_start", bus.uart_tx, 1'b0);
        check("b2b_busy", bus.busy, 1'b1);
        drain("b2b_drain");
        check("b2b_starts", (starts.size() >= 2), 1'b1);
        if (starts.size() >= 2) begin
            check("b2b_first_at", starts[$-1], m + 2);
            check("b2b_gap", starts[$] - starts[$-1], 10 * CLK_DIV);
        end

        // Overflow, then a write at full on the final STOP cycle
        for (int i = 0; i < 5; i++) sb.push_back(8'h11 + 8'(i));
        bus.wr_en = 1'b1; bus.wr_data = 8'h11;
        step(1);
        m = cyc;
        for (int i = 1; i < 6; i++) begin
            bus.wr_data = 8'h11 + 8'(i);
            step(1);
            if (i == 4) begin
                check("ovf_full",  bus.full,  1'b1);
                check("ovf_count", bus.count, 3'd4);
            end
        end
        bus.wr_en = 1'b0;
        check("ovf_drop_count", bus.count, 3'd4);
        check("ovf_drop_full",  bus.full,  1'b1);
        wait_until(m + 40);
        bus.wr_en = 1'b1; bus.wr_data = 8'h77;
        step(1);
        bus.wr_en = 1'b0;
        check("popfull_count", bus.count, 3'd3);
        check("popfull_full",  bus.full,  1'b0);
        check("popfull_empty", bus.empty, 1'b0);
        drain("ovf_drain");

        // Reset during data bit 3 of 0x0F
        sb.push_back(8'h0F);
        bus.wr_en = 1'b1; bus.wr_data = 8'h0F;
        step(1);
        n = cyc;
        bus.wr_en = 1'b0;
        wait_until(n + 18);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mrst_tx",    bus.uart_tx, 1'b1);
        check("mrst_busy",  bus.busy,    1'b0);
        check("mrst_empty", bus.empty,   1'b1);
        check("mrst_count", bus.count,   3'd0);
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            step(1);
            if (bus.uart_tx !== 1'b1 || bus.busy !== 1'b0) bad++;
        end
        check("mrst_quiet", bad, 0);
        drain("mrst_drain");

        // Recovery after reset
        sb.push_back(8'h3C);
        bus.wr_en = 1'b1; bus.wr_data = 8'h3C;
        step(1);
        bus.wr_en = 1'b0;
        drain("recover_drain");
        step(5);

        check("sb_empty", sb.size(), 0);
        check("frame_total", frames, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
